// File: rtl/palette_lut.sv
// Palette lookup: fetches a packed pixel index from the frame buffer in BRAM, then
// fetches that index's color from the selected palette. A one-word cache holds the last index word.
module palette_lut #(
  parameter int unsigned FB_BITS           = 17,
  parameter int unsigned BPP               = 8,
  parameter int unsigned PALETTE_SEL_BITS  = 2,
  parameter int unsigned COLOR_BYTES       = 2,
  parameter int unsigned PIXEL_COLOR_WIDTH = 12,
  parameter int unsigned BRAM_ADDR_BITS    = 32,
  parameter int unsigned BRAM_DATA_BITS    = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [FB_BITS-1:0]            pixel_index_i,
  input  logic [PALETTE_SEL_BITS-1:0]   palette_sel_i,
  input  logic                          fb_invalidate_i,
  output logic                          color_valid_o,
  input  logic                          color_ready_i,
  output logic [PIXEL_COLOR_WIDTH-1:0]  pixel_color_o,
  output logic                          bram_clk_o,
  output logic                          bram_rst_o,
  output logic                          bram_en_o,
  output logic [BRAM_ADDR_BITS-1:0]     bram_addr_o,
  input  logic [BRAM_DATA_BITS-1:0]     bram_dout_i,
  output logic [BRAM_DATA_BITS-1:0]     bram_din_o,
  output logic [BRAM_DATA_BITS/8-1:0]   bram_we_o
);

  localparam int unsigned WORD_BYTES = BRAM_DATA_BITS / 8;
  localparam int unsigned OFF_W      = $clog2(BRAM_DATA_BITS);
  localparam int unsigned WB_W       = $clog2(WORD_BYTES);
  localparam int unsigned PAL_SIZE   = COLOR_BYTES << BPP;
  localparam int unsigned FB_BASE    = PAL_SIZE << PALETTE_SEL_BITS;
  localparam int unsigned BA_W       = BRAM_ADDR_BITS + 3;

  typedef enum logic [2:0] {StIdle, StIdx, StClr, StLoad, StOut} state_e;

  state_e                        r_state, w_state_next;
  logic [PALETTE_SEL_BITS-1:0]   r_pal_sel;
  logic [BRAM_ADDR_BITS-1:0]     r_idx_addr;
  logic [OFF_W-1:0]              r_bit_off;
  logic                          r_miss;
  logic [WB_W-1:0]               r_col_off;
  logic [PIXEL_COLOR_WIDTH-1:0]  r_color;
  logic                          r_cache_valid;
  logic [BRAM_ADDR_BITS-1:0]     r_cache_tag;
  logic [BRAM_DATA_BITS-1:0]     r_cache_word;

  logic [BA_W-1:0]               w_bit_addr;
  logic [BRAM_ADDR_BITS-1:0]     w_idx_addr;
  logic                          w_hit;
  logic                          w_accept;
  logic [BRAM_DATA_BITS-1:0]     w_idx_word;
  logic [BPP-1:0]                w_index;
  logic [BRAM_ADDR_BITS-1:0]     w_col_byte;
  logic [BRAM_ADDR_BITS-1:0]     w_col_addr;
  logic [PIXEL_COLOR_WIDTH-1:0]  w_color;

  // Bit address of the pixel; word address keeps only whole-word bits, rescaled to bytes.
  assign w_bit_addr = (BA_W'(FB_BASE) << 3) + BA_W'(pixel_index_i) * BA_W'(BPP);
  assign w_idx_addr = {w_bit_addr[BA_W-1:OFF_W], {WB_W{1'b0}}};
  // An invalidate on the accept edge forces a miss.
  assign w_hit      = r_cache_valid && !fb_invalidate_i && (r_cache_tag == w_idx_addr);
  assign w_accept   = req_valid_i && req_ready_o;

  assign w_idx_word = r_miss ? bram_dout_i : r_cache_word;
  assign w_index    = BPP'(w_idx_word >> r_bit_off);
  assign w_col_byte = BRAM_ADDR_BITS'(r_pal_sel) * BRAM_ADDR_BITS'(PAL_SIZE)
                    + BRAM_ADDR_BITS'(w_index) * BRAM_ADDR_BITS'(COLOR_BYTES);
  assign w_col_addr = {w_col_byte[BRAM_ADDR_BITS-1:WB_W], {WB_W{1'b0}}};
  assign w_color    = PIXEL_COLOR_WIDTH'(bram_dout_i >> {r_col_off, 3'b000});

  always_comb begin
    w_state_next  = r_state;
    req_ready_o   = 1'b0;
    color_valid_o = 1'b0;
    bram_en_o     = 1'b0;
    bram_addr_o   = '0;
    unique case (r_state)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_next = w_hit ? StClr : StIdx;
      end
      StIdx: begin
        bram_en_o    = 1'b1;
        bram_addr_o  = r_idx_addr;
        w_state_next = StClr;
      end
      StClr: begin
        bram_en_o    = 1'b1;
        bram_addr_o  = w_col_addr;
        w_state_next = StLoad;
      end
      StLoad: w_state_next = StOut;
      StOut: begin
        color_valid_o = 1'b1;
        req_ready_o   = color_ready_i;
        if (color_ready_i) begin
          if (req_valid_i) w_state_next = w_hit ? StClr : StIdx;
          else             w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state       <= StIdle;
      r_pal_sel     <= '0;
      r_idx_addr    <= '0;
      r_bit_off     <= '0;
      r_miss        <= 1'b0;
      r_col_off     <= '0;
      r_color       <= '0;
      r_cache_valid <= 1'b0;
      r_cache_tag   <= '0;
      r_cache_word  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_pal_sel  <= palette_sel_i;
        r_idx_addr <= w_idx_addr;
        r_bit_off  <= w_bit_addr[OFF_W-1:0];
        r_miss     <= !w_hit;
      end
      if (r_state == StClr) r_col_off <= w_col_byte[WB_W-1:0];
      if (r_state == StLoad) r_color <= w_color;
      if (r_state == StClr && r_miss) begin
        r_cache_tag  <= r_idx_addr;
        r_cache_word <= bram_dout_i;
      end
      // Invalidate wins over a fill landing on the same edge: that word may be stale.
      if (fb_invalidate_i)                    r_cache_valid <= 1'b0;
      else if (r_state == StClr && r_miss)    r_cache_valid <= 1'b1;
    end
  end

  assign pixel_color_o = r_color;
  assign bram_clk_o    = clk_i;
  assign bram_rst_o    = ~reset_ni;
  assign bram_din_o    = '0;
  assign bram_we_o     = '0;

endmodule
